// File: rtl/pdm_mic_frontend.sv
// PDM mic front end: mic clock gen, dual-edge sampling, boxcar decimation.
// Optional DC blocker per channel when PDM_DC_BLOCK_EN is defined.
module pdm_mic_frontend #(
   parameter int PDM_COUNT_PERIOD = 32,
   parameter int NUM_PDM_SAMPLES  = 256,
   parameter int NUM_CH           = 1,
   parameter int OUT_W            = 16,
   parameter int DC_SHIFT         = 6
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    enable_in,
   input  logic                    mic_data_in,
   output logic                    mic_clk_out,
   output logic                    pdm_tick_out,
   output logic [NUM_CH*OUT_W-1:0] sample_out,
   output logic                    sample_valid_out
);

   localparam int LOG2N = $clog2(NUM_PDM_SAMPLES);
   localparam int CW    = $clog2(PDM_COUNT_PERIOD);
   localparam int HALF  = PDM_COUNT_PERIOD / 2;
   localparam int TW    = LOG2N + 1;
   localparam int SHIFT = OUT_W - 1 - LOG2N;
   localparam int LAST  = NUM_CH - 1;

   if ((PDM_COUNT_PERIOD % 2) != 0 || PDM_COUNT_PERIOD < 4) begin : g_bad_period
      $error("PDM_COUNT_PERIOD must be even and >= 4");
   end
   if (NUM_PDM_SAMPLES < 2 || (1 << LOG2N) != NUM_PDM_SAMPLES) begin : g_bad_n
      $error("NUM_PDM_SAMPLES must be a power of two >= 2");
   end
   if (OUT_W <= LOG2N || NUM_CH < 1 || NUM_CH > 2 || DC_SHIFT < 0) begin : g_bad_w
      $error("bad OUT_W / NUM_CH / DC_SHIFT");
   end

   logic [CW-1:0]           r_m_count;
   logic                    r_mic_clk;
   logic                    r_old_clk;
   logic                    w_rise;
   logic                    w_fall;
   logic [NUM_CH-1:0]       w_done;
   logic [NUM_CH*OUT_W-1:0] w_y_all;
   logic [NUM_CH*OUT_W-1:0] r_sample;
   logic                    r_valid;

   always_ff @(posedge clk_in) begin
      if (rst_in || !enable_in) begin
         r_m_count <= '0;
         r_mic_clk <= 1'b0;
         r_old_clk <= 1'b0;
      end else begin
         if (r_m_count == CW'(PDM_COUNT_PERIOD - 1)) begin
            r_m_count <= '0;
         end else begin
            r_m_count <= r_m_count + 1'b1;
         end
         r_mic_clk <= (r_m_count < CW'(HALF));
         r_old_clk <= r_mic_clk;
      end
   end

   // Gating by enable_in keeps the cycle enable drops free of stray ticks.
   assign w_rise = enable_in & r_mic_clk & ~r_old_clk;
   assign w_fall = enable_in & ~r_mic_clk & r_old_clk;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic                    w_tick;
      logic [LOG2N-1:0]        r_cnt;
      logic [TW-1:0]           r_tally;
      logic [TW-1:0]           r_hold;
      logic [TW-1:0]           w_sum;
      logic [TW-1:0]           w_final;
      logic signed [TW+1:0]    w_cent;
      logic signed [TW-1:0]    w_sat;
      logic signed [OUT_W-1:0] w_ext;
      logic signed [OUT_W-1:0] w_x;
      logic signed [OUT_W-1:0] w_y;

      if (g == 0) begin : g_rise
         assign w_tick = w_rise;
      end else begin : g_fall
         assign w_tick = w_fall;
      end

      assign w_sum   = r_tally + TW'(mic_data_in);
      assign w_done[g] = w_tick &&
                         (r_cnt == LOG2N'(NUM_PDM_SAMPLES - 1));
      assign w_final = w_done[g] ? w_sum : r_hold;

      always_ff @(posedge clk_in) begin
         if (rst_in || !enable_in) begin
            r_cnt   <= '0;
            r_tally <= '0;
         end else if (w_tick) begin
            r_cnt   <= r_cnt + 1'b1;
            r_tally <= w_done[g] ? '0 : w_sum;
         end
      end

      always_ff @(posedge clk_in) begin
         if (rst_in) begin
            r_hold <= '0;
         end else if (w_done[g]) begin
            r_hold <= w_sum;
         end
      end

      assign w_cent = $signed({1'b0, w_final, 1'b0}) -
                      $signed((TW + 2)'(NUM_PDM_SAMPLES));

      always_comb begin
         w_sat = w_cent[TW-1:0];
         if (w_cent == $signed((TW + 2)'(NUM_PDM_SAMPLES))) begin
            w_sat = TW'(NUM_PDM_SAMPLES - 1);
         end
      end

      assign w_ext = OUT_W'(w_sat);
      assign w_x   = w_ext <<< SHIFT;

`ifdef PDM_DC_BLOCK_EN
      localparam int DW = OUT_W + DC_SHIFT;
      localparam logic signed [DW:0] SAT_HI =
         (DW + 1)'({1'b0, {(OUT_W - 1){1'b1}}});
      localparam logic signed [DW:0] SAT_LO = ~SAT_HI;

      logic signed [DW-1:0] r_dc;
      logic signed [DW-1:0] w_dc_hi;
      logic signed [DW:0]   w_diff;

      assign w_dc_hi = r_dc >>> DC_SHIFT;
      assign w_diff  = (DW + 1)'(w_x) - (DW + 1)'(w_dc_hi);

      always_comb begin
         w_y = w_diff[OUT_W-1:0];
         if (w_diff > SAT_HI) begin
            w_y = SAT_HI[OUT_W-1:0];
         end else if (w_diff < SAT_LO) begin
            w_y = SAT_LO[OUT_W-1:0];
         end
      end

      // Leaky tracker advances once per output sample.
      always_ff @(posedge clk_in) begin
         if (rst_in) begin
            r_dc <= '0;
         end else if (w_done[LAST]) begin
            r_dc <= r_dc + DW'(w_x) - w_dc_hi;
         end
      end
`else
      assign w_y = w_x;
`endif

      assign w_y_all[g*OUT_W +: OUT_W] = w_y;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_sample <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= w_done[LAST];
         if (w_done[LAST]) begin
            r_sample <= w_y_all;
         end
      end
   end

   assign mic_clk_out      = r_mic_clk;
   assign pdm_tick_out     = w_rise;
   assign sample_out       = r_sample;
   assign sample_valid_out = r_valid;

endmodule
